// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched entries with a registered head and flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_nxt  = rd_ptr + 1'b1;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // The head register always mirrors mem[rd_ptr] while non-empty, so the
  // next head is either the incoming word or the entry behind the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push && (empty || (do_pop && count == CNT_W'(1))))
        head <= wdata;
      else if (do_pop && count > CNT_W'(1))
        head <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, redirect squash, buffer to decode.
// Optional FETCH_MISALIGN_TRAP_EN adds a sticky misalign output that halts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [31:0]      redir_target;
  logic             drop;
  logic             accept;
  logic             rsp_take;
  logic             push;
  logic             pop;
  logic             run_nxt;
  logic             mis_q;
  logic             mis_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             empty;
  logic             full;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign accept     = imem_req_valid && imem_req_ready;
  assign rsp_take   = (state == WAIT) && imem_rsp_valid;
  assign push       = rsp_take && !drop && !redirect_valid && (!full || pop);
  assign inst_valid = !empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign push_entry = '{pc: req_pc, inst: imem_rsp_data};
  assign count_nxt  = redirect_valid ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign run_nxt    = (state == WAIT) ? imem_rsp_valid : !accept;

  assign imem_req_addr = align_pc(fetch_pc);
  assign inst_data     = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc4      = empty ? '0 : next_pc(head.pc);

`ifdef FETCH_MISALIGN_TRAP_EN
  // The unaligned target is kept whole; fetch stays halted until realigned.
  assign redir_target = redirect_pc;
  assign mis_nxt      = redirect_valid ? (redirect_pc[1:0] != 2'b00) : mis_q;
  assign misalign     = mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_nxt;
  end
`else
  assign redir_target = align_pc(redirect_pc);
  assign mis_nxt      = 1'b0;
  assign mis_q        = 1'b0;
`endif

  // Request valid is registered from next-state values so it is low in reset
  // and only changes when the request is accepted or withdrawn by a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
    end else begin
      imem_req_valid <= run_nxt && (count_nxt < CNT_W'(BUF_DEPTH)) && !mis_nxt;
      if (redirect_valid) begin
        fetch_pc <= redir_target;
        if (accept) begin
          state  <= WAIT;
          req_pc <= fetch_pc;
          drop   <= 1'b1;
        end else if (rsp_take) begin
          state <= RUN;
          drop  <= 1'b0;
        end else if (state == WAIT) begin
          drop <= 1'b1;
        end
      end else if (accept) begin
        state    <= WAIT;
        req_pc   <= fetch_pc;
        fetch_pc <= next_pc(fetch_pc);
      end else if (rsp_take) begin
        state <= RUN;
        drop  <= 1'b0;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule
